// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - load funct3 codes (LB, LH, LW, LBU, LHU)
//   - responder FSM state enum
//   - legal store byte-lane masks and a legality helper
package dmem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load extraction from a 32-bit word.
// Ports:
//   i_word   - word read from the backing array
//   i_offset - byte offset within the word (addr[1:0])
//   i_funct3 - load type (lb/lh/lw/lbu/lhu)
//   o_data   - extended load data, 0 when o_err is set
//   o_err    - misaligned access or unsupported funct3
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_word >> {i_offset, 3'b000};
  assign w_byte    = w_shifted[7:0];
  // Halves only ever come from offset 0 or 2; offset[0] is an error case.
  assign w_half    = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = 32'h0;
    o_err  = 1'b0;
    case (i_funct3)
      LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LBU: o_data = {24'h0, w_byte};
      LH: begin
        if (i_offset[0]) o_err  = 1'b1;
        else             o_data = {{16{w_half[15]}}, w_half};
      end
      LHU: begin
        if (i_offset[0]) o_err  = 1'b1;
        else             o_data = {16'h0, w_half};
      end
      LW: begin
        if (i_offset != 2'b00) o_err  = 1'b1;
        else                   o_data = i_word;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: multi-cycle data-memory responder for the core's load/store
// port. One request at a time, fixed access latency, one response per request.
// Optional feature: define DMEM_RANGE_CHECK_EN to flag any nonzero address bit
// above the array as an error (otherwise the address wraps).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid/req_ready       - request handshake (ready only in IDLE)
//   req_addr, req_load, req_funct3, req_be, req_wdata - request fields
//   rsp_valid/rsp_ready       - response handshake
//   rsp_rdata, rsp_err        - response payload, held until handshake
//
// state  | meaning
// IDLE   | ready for a request; fields latched on req_valid
// BUSY   | counting down the access latency
// COMMIT | write performed / load extracted; response registered
// RESP   | rsp_valid high, waiting for rsp_ready
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     req_load,
  input  logic [2:0]               req_funct3,
  input  logic [3:0]               req_be,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t r_state, w_state_nxt;
  logic [3:0]                r_cnt;
  logic [MEM_DEPTH_LOG2-1:0] r_idx;
  logic [1:0]                r_off;
  logic                      r_load;
  logic [2:0]                r_funct3;
  logic [3:0]                r_be;
  logic [31:0]               r_wdata;
  logic                      r_oor;
  logic [31:0]               r_rdata;
  logic                      r_err;
  logic [31:0]               r_mem [0:(1<<MEM_DEPTH_LOG2)-1];

  logic [31:0] w_word;
  logic [31:0] w_ld_data;
  logic        w_ld_err;
  logic        w_range_err;
  logic        w_err;
  logic        w_wr_en;

  assign w_range_err = RANGE_CHK && (|req_addr[ADDRESS_WIDTH-1:MEM_DEPTH_LOG2+2]);

  assign w_word = r_mem[r_idx];

  dmem_load_align u_align (
    .i_word   (w_word),
    .i_offset (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_ld_data),
    .o_err    (w_ld_err)
  );

  always_comb begin
    w_err = 1'b0;
    if (r_load && (r_be != 4'h0))        w_err = 1'b1;
    if (!r_load && (r_be == 4'h0))       w_err = 1'b1;
    if (!r_load && !be_legal(r_be))      w_err = 1'b1;
    if (r_load && w_ld_err)              w_err = 1'b1;
    if (r_oor)                           w_err = 1'b1;
  end

  assign w_wr_en = (r_state == COMMIT) && !r_load && !w_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (req_valid) w_state_nxt = (LATENCY == 1) ? COMMIT : BUSY;
      // Counter is decremented this cycle; reaching 0 moves on to COMMIT.
      BUSY:   if (r_cnt <= 4'd1) w_state_nxt = COMMIT;
      COMMIT: w_state_nxt = RESP;
      RESP:   if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (req_valid) begin
          r_idx    <= req_addr[MEM_DEPTH_LOG2+1:2];
          r_off    <= req_addr[1:0];
          r_load   <= req_load;
          r_funct3 <= req_funct3;
          r_be     <= req_be;
          r_wdata  <= req_wdata;
          r_oor    <= w_range_err;
          r_cnt    <= LAT_M1;
        end
        BUSY: r_cnt <= r_cnt - 4'd1;
        COMMIT: begin
          r_err   <= w_err;
          r_rdata <= (w_err || !r_load) ? 32'h0 : w_ld_data;
        end
        default: ;
      endcase
    end
  end

  // Reset wins over a store landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_resp #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .MEM_DEPTH_LOG2(10),
    .LATENCY       (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_load   (req_load),
    .req_funct3 (req_funct3),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    string       name;
    logic        load;
    logic [2:0]  f3;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic ld, logic [2:0] f3, logic [3:0] be,
                              logic [31:0] a, logic [31:0] wd, logic e, logic [31:0] rd);
    vec_t v;
    v.name = n; v.load = ld; v.f3 = f3; v.be = be; v.addr = a;
    v.wdata = wd; v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs driven and outputs sampled at the falling edge.
  task automatic txn(input string name, input logic ld, input logic [2:0] f3,
                     input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                     output logic err, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    chk({name, "/req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_be = be;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "/latency"}, 32'(lat), 32'(LAT + 1));
    err = rsp_err;
    rd  = rsp_rdata;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic        t_err;
  logic [31:0] t_rd;
  logic [31:0] hold_rd;
  logic        hold_err;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_load = 1'b0;
    req_funct3 = 3'b0; req_be = 4'h0; req_wdata = '0; rsp_ready = 1'b0;

    vecs.push_back(mk("st_word",   0, LW,     4'b1111, 32'h10, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk("lw_10",     1, LW,     4'b0000, 32'h10, 32'h0, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lb_13",     1, LB,     4'b0000, 32'h13, 32'h0, 0, 32'hFFFFFFDE));
    vecs.push_back(mk("lbu_13",    1, LBU,    4'b0000, 32'h13, 32'h0, 0, 32'h000000DE));
    vecs.push_back(mk("lhu_12",    1, LHU,    4'b0000, 32'h12, 32'h0, 0, 32'h0000DEAD));
    vecs.push_back(mk("lh_10",     1, LH,     4'b0000, 32'h10, 32'h0, 0, 32'hFFFFBEEF));
    vecs.push_back(mk("st_b1",     0, LW,     4'b0010, 32'h10, 32'h00001200, 0, 32'h0));
    vecs.push_back(mk("lw_after",  1, LW,     4'b0000, 32'h10, 32'h0, 0, 32'hDEAD12EF));
    vecs.push_back(mk("lh_mis",    1, LH,     4'b0000, 32'h11, 32'h0, 1, 32'h0));
    vecs.push_back(mk("st_be0110", 0, LW,     4'b0110, 32'h10, 32'hFFFFFFFF, 1, 32'h0));
    vecs.push_back(mk("lw_nowr",   1, LW,     4'b0000, 32'h10, 32'h0, 0, 32'hDEAD12EF));
    vecs.push_back(mk("lw_mis",    1, LW,     4'b0000, 32'h12, 32'h0, 1, 32'h0));
    vecs.push_back(mk("f3_011",    1, 3'b011, 4'b0000, 32'h10, 32'h0, 1, 32'h0));
    vecs.push_back(mk("ld_be",     1, LW,     4'b0001, 32'h10, 32'h0, 1, 32'h0));
    vecs.push_back(mk("st_be0",    0, LW,     4'b0000, 32'h10, 32'h0, 1, 32'h0));
    vecs.push_back(mk("lw_still",  1, LW,     4'b0000, 32'h10, 32'h0, 0, 32'hDEAD12EF));
    vecs.push_back(mk("st_20",     0, LW,     4'b1111, 32'h20, 32'hA5A5A5A5, 0, 32'h0));
    vecs.push_back(mk("lb_pos",    1, LB,     4'b0000, 32'h11, 32'h0, 0, 32'h00000012));
    vecs.push_back(mk("lh_12",     1, LH,     4'b0000, 32'h12, 32'h0, 0, 32'hFFFFDEAD));
    vecs.push_back(mk("st_h1",     0, LW,     4'b1100, 32'h23, 32'h12340000, 0, 32'h0));
    vecs.push_back(mk("lw_20",     1, LW,     4'b0000, 32'h20, 32'h0, 0, 32'h1234A5A5));
`ifdef DMEM_RANGE_CHECK_EN
    vecs.push_back(mk("lw_oor",    1, LW,     4'b0000, 32'h1000, 32'h0, 1, 32'h0));
    vecs.push_back(mk("lw_oor2",   1, LW,     4'b0000, 32'h1010, 32'h0, 1, 32'h0));
`else
    vecs.push_back(mk("lw_wrap",   1, LW,     4'b0000, 32'h1010, 32'h0, 0, 32'hDEAD12EF));
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst/rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst/rsp_rdata", rsp_rdata, 32'h0);
    chk("rst/rsp_err",   {31'h0, rsp_err}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i].name, vecs[i].load, vecs[i].f3, vecs[i].be, vecs[i].addr,
          vecs[i].wdata, t_err, t_rd);
      chk({vecs[i].name, "/err"},   {31'h0, t_err}, {31'h0, vecs[i].exp_err});
      chk({vecs[i].name, "/rdata"}, t_rd, vecs[i].exp_rdata);
    end

    // Response stall with a rejected request pulse in the middle.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = LW; req_be = 4'h0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    chk("stall/rsp_valid0", {31'h0, rsp_valid}, 32'h1);
    hold_rd = rsp_rdata; hold_err = rsp_err;
    chk("stall/rdata0", hold_rd, 32'h1234A5A5 & 32'h0 | 32'hDEAD12EF);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req_valid = 1'b1; req_load = 1'b0; req_be = 4'b1111;
        req_addr = 32'h10; req_wdata = 32'h0;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      chk("stall/rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("stall/rdata",     rsp_rdata, 32'hDEAD12EF);
      chk("stall/err",       {31'h0, rsp_err}, 32'h0);
      chk("stall/req_ready", {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall/after_valid", {31'h0, rsp_valid}, 32'h0);
    txn("stall_noacc", 1'b1, LW, 4'h0, 32'h10, 32'h0, t_err, t_rd);
    chk("stall_noacc/rdata", t_rd, 32'hDEAD12EF);

    // Reset in the COMMIT cycle of a store drops it and issues no response.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_be = 4'b1111;
    req_addr = 32'h20; req_wdata = 32'h11111111;
    @(negedge clk);            // BUSY
    req_valid = 1'b0;
    @(negedge clk);            // COMMIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rstmid/rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rstmid/req_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
    end
    txn("rstmid_lw", 1'b1, LW, 4'h0, 32'h20, 32'h0, t_err, t_rd);
    chk("rstmid_lw/rdata", t_rd, 32'h1234A5A5);
    chk("rstmid_lw/err",   {31'h0, t_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
